// File: rtl/rc4_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rc4_pkg
// Description : Shared types and constants for the RC4 key-scheduling stage:
//               byte type, S-array size, default key length and the KSA
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rc4_pkg;

  // One S-array entry / one key byte
  typedef logic [7:0] byte_t;

  // Number of entries in the S RAM
  localparam int S_SIZE = 256;

  // Default secret key length in bytes
  localparam int KEY_BYTES_DEFAULT = 3;

  // Width of the KSA state register
  localparam int KSA_STATE_W = 4;

  // KSA sequencer states; each iteration walks READ_I .. WRITE_J (8 cycles)
  typedef enum logic [KSA_STATE_W-1:0] {
    IDLE    = 4'd0,
    READ_I  = 4'd1,
    WAIT_I  = 4'd2,
    LATCH_I = 4'd3,
    READ_J  = 4'd4,
    WAIT_J  = 4'd5,
    LATCH_J = 4'd6,
    WRITE_I = 4'd7,
    WRITE_J = 4'd8,
    DONE    = 4'd9
  } ksa_state_t;

endpackage : rc4_pkg
`default_nettype wire

// File: rtl/key_byte_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_byte_sel
// Description : Combinational key-byte selector. Byte 0 of the key is the
//               most significant byte of the key vector, so index k picks
//               bits [8*(KEY_BYTES-1-k) +: 8].
// Revision    : 1.0 - initial release
// ============================================================================
module key_byte_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT,
  parameter int IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [8*KEY_BYTES-1:0] i_key,
  input  logic [IDX_W-1:0]       i_key_idx,
  output byte_t                  o_key_byte
);

  // Priority-free one-hot style mux over the key bytes; out-of-range
  // indices (never produced by the wrapping counter) yield zero.
  always_comb begin
    o_key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (i_key_idx == k[IDX_W-1:0]) begin
        o_key_byte = i_key[8*(KEY_BYTES-1-k) +: 8];
      end
    end
  end

endmodule : key_byte_sel
`default_nettype wire

// File: rtl/ksa_swapper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ksa_swapper
// Description : RC4 key-scheduling stage. For i = 0..255 computes
//               j = j + S[i] + key[i mod KEY_BYTES] and swaps S[i] / S[j]
//               in an external single-port 256x8 RAM. All RAM-side outputs
//               are registered: they are decoded from the next state so that
//               each value is present for the whole cycle of its state.
// Revision    : 1.0 - initial release
// ============================================================================
module ksa_swapper
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  input  byte_t                  s_q,
  output byte_t                  s_address,
  output byte_t                  s_data,
  output logic                   s_wren,
  output logic                   busy,
  output logic                   finish
);

  localparam int               IDX_W          = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [IDX_W-1:0] C_KEY_IDX_LAST = IDX_W'(KEY_BYTES - 1);
  localparam byte_t            C_I_LAST       = byte_t'(S_SIZE - 1);

  // Registered state
  ksa_state_t             r_state;
  logic [8*KEY_BYTES-1:0] r_key;
  byte_t                  r_i;
  byte_t                  r_j;
  byte_t                  r_si;
  byte_t                  r_sj;
  logic [IDX_W-1:0]       r_key_idx;
  byte_t                  r_s_address;
  byte_t                  r_s_data;
  logic                   r_s_wren;
  logic                   r_busy;
  logic                   r_finish;

  // Next-state values
  ksa_state_t             w_state_nxt;
  logic [8*KEY_BYTES-1:0] w_key_nxt;
  byte_t                  w_i_nxt;
  byte_t                  w_j_nxt;
  byte_t                  w_si_nxt;
  byte_t                  w_sj_nxt;
  logic [IDX_W-1:0]       w_key_idx_nxt;
  byte_t                  w_s_address_nxt;
  byte_t                  w_s_data_nxt;
  logic                   w_s_wren_nxt;
  logic                   w_busy_nxt;
  logic                   w_finish_nxt;
  byte_t                  w_key_byte;

  // Key byte for the current iteration, chosen from the latched key
  key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .IDX_W     (IDX_W)
  ) u_key_byte_sel (
    .i_key      (r_key),
    .i_key_idx  (r_key_idx),
    .o_key_byte (w_key_byte)
  );

  // State register; asynchronous reset drops the sequencer back to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, datapath updates and output decode from the next state
  always_comb begin
    w_state_nxt     = r_state;
    w_key_nxt       = r_key;
    w_i_nxt         = r_i;
    w_j_nxt         = r_j;
    w_si_nxt        = r_si;
    w_sj_nxt        = r_sj;
    w_key_idx_nxt   = r_key_idx;
    w_s_address_nxt = r_s_address;
    w_s_data_nxt    = r_s_data;
    w_s_wren_nxt    = 1'b0;
    w_finish_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_key_nxt     = key;
          w_i_nxt       = '0;
          w_j_nxt       = '0;
          w_key_idx_nxt = '0;
          w_state_nxt   = READ_I;
        end
      end
      READ_I:  w_state_nxt = WAIT_I;
      WAIT_I:  w_state_nxt = LATCH_I;
      LATCH_I: begin
        w_si_nxt    = s_q;
        w_j_nxt     = r_j + s_q + w_key_byte;
        w_state_nxt = READ_J;
      end
      READ_J:  w_state_nxt = WAIT_J;
      WAIT_J:  w_state_nxt = LATCH_J;
      LATCH_J: begin
        w_sj_nxt    = s_q;
        w_state_nxt = WRITE_I;
      end
      WRITE_I: w_state_nxt = WRITE_J;
      WRITE_J: begin
        if (r_i == C_I_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_i_nxt       = r_i + 8'd1;
          w_key_idx_nxt = (r_key_idx == C_KEY_IDX_LAST) ? '0 : r_key_idx + IDX_W'(1);
          w_state_nxt   = READ_I;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // The RAM port presents during state X what X asks for, so the
    // registered outputs are loaded from the state being entered. In the
    // i==j case both writes carry S[i], leaving the array unchanged.
    case (w_state_nxt)
      READ_I:  w_s_address_nxt = w_i_nxt;
      READ_J:  w_s_address_nxt = w_j_nxt;
      WRITE_I: begin
        w_s_address_nxt = w_i_nxt;
        w_s_data_nxt    = w_sj_nxt;
        w_s_wren_nxt    = 1'b1;
      end
      WRITE_J: begin
        w_s_address_nxt = w_j_nxt;
        w_s_data_nxt    = w_si_nxt;
        w_s_wren_nxt    = 1'b1;
      end
      DONE:    w_finish_nxt = 1'b1;
      default: ;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // Datapath and registered RAM/status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_si        <= '0;
      r_sj        <= '0;
      r_key_idx   <= '0;
      r_s_address <= '0;
      r_s_data    <= '0;
      r_s_wren    <= 1'b0;
      r_busy      <= 1'b0;
      r_finish    <= 1'b0;
    end else begin
      r_key       <= w_key_nxt;
      r_i         <= w_i_nxt;
      r_j         <= w_j_nxt;
      r_si        <= w_si_nxt;
      r_sj        <= w_sj_nxt;
      r_key_idx   <= w_key_idx_nxt;
      r_s_address <= w_s_address_nxt;
      r_s_data    <= w_s_data_nxt;
      r_s_wren    <= w_s_wren_nxt;
      r_busy      <= w_busy_nxt;
      r_finish    <= w_finish_nxt;
    end
  end

  assign s_address = r_s_address;
  assign s_data    = r_s_data;
  assign s_wren    = r_s_wren;
  assign busy      = r_busy;
  assign finish    = r_finish;

endmodule : ksa_swapper
`default_nettype wire

// File: doc/ksa_swapper.md
Name: ksa_swapper

Overview:
- RC4 key-scheduling (KSA) stage. Runs after the S-array initializer has written s[i]=i into the 256x8 S RAM.
- Iterates i=0..255: j = j + s[i] + key[i mod KEY_BYTES], then swaps s[i] and s[j].
- Drives the same single-port S RAM through a mux that the top level controls.
- Pulses finish when done, which releases the downstream PRGA/decrypt stage.

Parameters:
- KEY_BYTES, 3, secret key length in bytes; key width = 8*KEY_BYTES.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset (see Behaviour)
- start  in  1  begin KSA; sampled only in IDLE
- key  in  8*KEY_BYTES  secret key; most significant byte is key byte 0
- s_q  in  8  S RAM read data
- s_address  out  8  S RAM address (registered)
- s_data  out  8  S RAM write data (registered)
- s_wren  out  1  S RAM write enable (registered)
- busy  out  1  high in every state except IDLE
- finish  out  1  one-cycle pulse when KSA completes

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock clk. Reset value of every output is 0. Internal i, j, si, sj and key_idx reset to 0; state resets to IDLE.
- RAM timing: s_address is valid during state X. The RAM registers the address at the end of X. s_q is valid during X+1 and is sampled at the end of X+1.
- IDLE: on start=1, latch key into key_r and clear i, j and key_idx to 0, then go to READ_I. start=0 stays in IDLE. start is ignored in all other states.
- READ_I: s_address=i, s_wren=0. Next state WAIT_I.
- WAIT_I: no action. Next state LATCH_I.
- LATCH_I: si<=s_q; j<=j+s_q+key_r byte[key_idx], mod 256 (8-bit wrap). Next state READ_J.
- READ_J: s_address=j, using the updated j. Next state WAIT_J.
- WAIT_J: no action. Next state LATCH_J.
- LATCH_J: sj<=s_q. Next state WRITE_I.
- WRITE_I: s_address=i, s_data=sj, s_wren=1. Next state WRITE_J.
- WRITE_J: s_address=j, s_data=si, s_wren=1.
  - If i==255, go to DONE.
  - Otherwise i<=i+1; key_idx<=(key_idx==KEY_BYTES-1)?0:key_idx+1; go to READ_I.
- key_idx is a wrapping counter; no divide or modulo hardware.
- DONE: finish=1 for exactly one cycle, s_wren=0, then IDLE. i and j hold their final values.
- Per iteration: 8 cycles. Total: 2048 cycles from the first READ_I to DONE.
- Writes per run: exactly 512 (two per iteration). s_wren is never high outside WRITE_I/WRITE_J.
- i==j case: WRITE_I and WRITE_J both write si to the same address, so S is unchanged. This is correct and needs no special casing.
- No read-after-write hazard: both writes of an iteration complete before the next READ_I.
- Reset mid-operation: returns to IDLE immediately with s_wren=0. The S RAM is left partially permuted; the controller must rerun the initializer before restarting.
- key changes after start is accepted have no effect, because key_r is latched.

Decomposition:
- rc4_pkg:
  - typedef byte_t (logic [7:0]).
  - enum ksa_state_t (IDLE, READ_I, WAIT_I, LATCH_I, READ_J, WAIT_J, LATCH_J, WRITE_I, WRITE_J, DONE).
  - constant S_SIZE=256.
  - default KEY_BYTES=3.
- Optional sub-module key_byte_sel: combinational mux from key_r and key_idx to byte_t. Everything else stays in ksa_swapper.

Test Plan:
- Behavioural 256x8 RAM preloaded with s[i]=i; key=24'h000000; pulse start.
  - After iteration i=2: s[2]=8'h03, s[3]=8'h02.
  - At finish, all 256 entries match a software KSA model.
- key=24'h000249 from s[i]=i.
  - finish pulses exactly once, 2048 cycles after the first READ_I (about 2049 cycles after the start edge).
  - Final RAM matches the model.
  - The bench counts exactly 512 s_wren cycles.
- KEY_BYTES=5, key=40'h0102030405: final S matches the model, checking key_idx wrap at 5.
- start held high throughout a run and re-pulsed mid-run: no restart and no extra finish. After returning to IDLE, a new start begins a new run.
- reset_n asserted low during iteration 100, at WRITE_I:
  - Outputs go to 0 asynchronously and busy=0.
  - After reinitializing the RAM and restarting, the final S matches the model.
- Key sampling check: change key one cycle after start is accepted; the final S still matches the model for the original key.
